router_pkt_reader: RTL

//  Read-side engine for one router output FIFO. Drains packets of the form header,

---
 rtl/router_pkt_reader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/router_pkt_reader.sv
// Read-side engine for one router output FIFO: drains header/payload/parity packets
// onto a byte stream with sop/eop framing, parity checking and stall timeout.
module router_pkt_reader #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       fifo_soft_rst,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_dest,
  output logic       parity_err,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PAR} state_t;

  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             vld_p0;
  logic [5:0]       len_cnt;
  logic [7:0]       par_acc;
  logic             par_bad;
  logic [CNT_W-1:0] stall_cnt;
  logic             xfer;
  logic             stall;
  logic             timeout_hit;

  assign xfer        = out_valid & out_ready;
  assign stall       = out_valid & ~out_ready;
  assign timeout_hit = stall && (stall_cnt == STALL_LAST);

  // A pending eop beat blocks the next header read so packets never overlap in state.
  assign fifo_rd_en = !rst && !fifo_empty && !vld_p0 && !fifo_soft_rst &&
                      (!out_valid || out_ready) && !(out_valid && out_eop);

  assign parity_err = xfer & out_eop & par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      vld_p0        <= 1'b0;
      len_cnt       <= '0;
      par_acc       <= '0;
      par_bad       <= 1'b0;
      stall_cnt     <= '0;
      fifo_soft_rst <= 1'b0;
      timeout_err   <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_dest      <= '0;
    end else begin
      fifo_soft_rst <= 1'b0;
      timeout_err   <= 1'b0;
      if (timeout_hit) begin
        fifo_soft_rst <= 1'b1;
        timeout_err   <= 1'b1;
        out_valid     <= 1'b0;
        out_sop       <= 1'b0;
        out_eop       <= 1'b0;
        vld_p0        <= 1'b0;
        state         <= IDLE;
        stall_cnt     <= '0;
        par_acc       <= '0;
        par_bad       <= 1'b0;
      end else begin
        // Stage p0: read issued this cycle, data present on fifo_dout next cycle.
        vld_p0 <= fifo_rd_en;
        if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
        else       stall_cnt <= '0;
        if (fifo_rd_en && state == IDLE) state <= HDR;

        if (xfer) begin
          out_valid <= 1'b0;
          out_sop   <= 1'b0;
          out_eop   <= 1'b0;
          if (out_eop) begin
            state   <= IDLE;
            par_bad <= 1'b0;
          end
        end

        // Stage p1: landed byte moves into the output register.
        if (vld_p0) begin
          out_valid <= 1'b1;
          out_data  <= fifo_dout;
          out_sop   <= (state == HDR);
          out_eop   <= (state == PAR);
          case (state)
            HDR: begin
              len_cnt  <= fifo_dout[7:2];
              out_dest <= fifo_dout[1:0];
              par_acc  <= fifo_dout;
              state    <= (fifo_dout[7:2] == 6'd0) ? PAR : PAYLOAD;
            end
            PAYLOAD: begin
              par_acc <= par_acc ^ fifo_dout;
              len_cnt <= len_cnt - 6'd1;
              if (len_cnt == 6'd1) state <= PAR;
            end
            PAR: begin
              par_bad <= (par_acc != fifo_dout);
              par_acc <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
